// File: rtl/display_pkg.sv
// Shared types and defaults for the scrolling display slice.
package display_pkg;

  // Scroller control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // DIR_LEFT enters at digit 0 and moves toward the top digit;
  // DIR_RIGHT enters at the top digit and moves toward digit 0.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int                   DEF_DIGIT_W = 4;
  localparam logic [DEF_DIGIT_W-1:0] DEF_BLANK = 4'h0;

endpackage

// File: rtl/digit_shift_reg.sv
// Bidirectional digit-wide shift register holding the visible display digits.
module digit_shift_reg
  import display_pkg::*;
#(
  parameter int                 N_DIGITS = 8,
  parameter int                 DIGIT_W  = DEF_DIGIT_W,
  parameter logic [DIGIT_W-1:0] BLANK    = DIGIT_W'(DEF_BLANK)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clr_i,
  input  logic                        shift_en_i,
  input  dir_e                        dir_i,
  input  logic [DIGIT_W-1:0]          din_i,
  output logic [N_DIGITS*DIGIT_W-1:0] q_o
);

  logic [N_DIGITS*DIGIT_W-1:0] digits_q;

  // Clear wins over shifting; a shift drops the digit at the far end.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      digits_q <= {N_DIGITS{BLANK}};
    end else if (clr_i) begin
      digits_q <= {N_DIGITS{BLANK}};
    end else if (shift_en_i) begin
      if (dir_i == DIR_LEFT) begin
        digits_q <= {digits_q[(N_DIGITS-1)*DIGIT_W-1:0], din_i};
      end else begin
        digits_q <= {din_i, digits_q[N_DIGITS*DIGIT_W-1:DIGIT_W]};
      end
    end
  end

  assign q_o = digits_q;

endmodule

// File: rtl/display_scroller.sv
// Scrolls a latched hex message across the display, with a blank gap
// between passes and either continuous or one-shot operation.
module display_scroller
  import display_pkg::*;
#(
  parameter int                 N_DIGITS = 8,
  parameter int                 DIGIT_W  = DEF_DIGIT_W,
  parameter int                 MSG_LEN  = 8,
  parameter int                 GAP      = 8,
  parameter logic [DIGIT_W-1:0] BLANK    = DIGIT_W'(DEF_BLANK)
) (
  input  logic                               clk_10Mhz_i,
  input  logic                               rst_n_i,
  input  logic                               clk_en_i,
  input  logic                               pause_i,
  input  logic                               load_i,
  input  logic [MSG_LEN*DIGIT_W-1:0]         msg_i,
  input  logic                               dir_i,
  input  logic                               mode_i,
  output logic [N_DIGITS*DIGIT_W-1:0]        display_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [$clog2(MSG_LEN+GAP+1)-1:0]   step_o
);

  localparam int             SW       = $clog2(MSG_LEN+GAP+1);
  localparam logic [SW-1:0]  PASS_LEN = SW'(MSG_LEN + GAP);
  localparam logic [SW-1:0]  MSG_END  = SW'(MSG_LEN);

  state_t                     state_q;
  logic [SW-1:0]              stepCnt_q;
  logic [SW-1:0]              stepCnt_d;
  logic [MSG_LEN*DIGIT_W-1:0] msg_q;
  logic [MSG_LEN*DIGIT_W-1:0] msgShifted;
  dir_e                       dir_q;
  logic                       mode_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       stepEn;
  logic                       passEnd;
  logic                       enterFlush;
  logic [DIGIT_W-1:0]         dinSel;

  // Decode a step and pick the digit that enters the display on it.
  always_comb begin
    stepEn     = clk_en_i & ~pause_i & ~load_i &
                 ((state_q == RUN) | (state_q == FLUSH));
    stepCnt_d  = stepCnt_q + SW'(1);
    passEnd    = (stepCnt_d == PASS_LEN);
    enterFlush = (GAP > 0) && (stepCnt_d == MSG_END);
    msgShifted = msg_q >> (DIGIT_W * int'(stepCnt_q));
    dinSel     = (state_q == FLUSH) ? BLANK : msgShifted[DIGIT_W-1:0];
  end

  // Control FSM with step counter; load beats everything, one-shot ends in DONE.
  always_ff @(posedge clk_10Mhz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      stepCnt_q <= '0;
      msg_q     <= '0;
      dir_q     <= DIR_LEFT;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        msg_q     <= msg_i;
        dir_q     <= dir_e'(dir_i);
        mode_q    <= mode_i;
        stepCnt_q <= '0;
        state_q   <= RUN;
        busy_q    <= 1'b1;
      end else if (stepEn) begin
        if (passEnd) begin
          if (mode_q) begin
            stepCnt_q <= stepCnt_d;
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            stepCnt_q <= '0;
            state_q   <= RUN;
          end
        end else begin
          stepCnt_q <= stepCnt_d;
          if (enterFlush) begin
            state_q <= FLUSH;
          end
        end
      end
    end
  end

  digit_shift_reg #(
    .N_DIGITS (N_DIGITS),
    .DIGIT_W  (DIGIT_W),
    .BLANK    (BLANK)
  ) u_shift (
    .clk_i      (clk_10Mhz_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (load_i),
    .shift_en_i (stepEn),
    .dir_i      (dir_q),
    .din_i      (dinSel),
    .q_o        (display_o)
  );

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign step_o = stepCnt_q;

endmodule

// File: tb/tb_display_scroller.sv
// Self-checking bench for display_scroller: directed scenarios followed by
// randomized traffic, all checked against a stream-based reference model.
`timescale 1ns/1ps
module tb_display_scroller;

  localparam int PASS_A = 16;

  logic        clk;
  logic        rstN;
  logic        clkEn;
  logic        pause;
  logic        load;
  logic [31:0] msgA;
  logic [23:0] msgB;
  logic        dir;
  logic        mode;
  logic [31:0] dispA;
  logic        busyA;
  logic        doneA;
  logic [4:0]  stepA;
  logic [15:0] dispB;
  logic        busyB;
  logic        doneB;
  logic [2:0]  stepB;

  int checks = 0;
  int errors = 0;

  // Reference model: number of effective steps since the last load.
  int          mSteps  = 0;
  bit          mLoaded = 0;
  bit          mMode   = 0;
  bit          mDir    = 0;
  logic [31:0] mMsg    = '0;
  bit          expDone = 0;

  display_scroller dutA (
    .clk_10Mhz_i (clk),
    .rst_n_i     (rstN),
    .clk_en_i    (clkEn),
    .pause_i     (pause),
    .load_i      (load),
    .msg_i       (msgA),
    .dir_i       (dir),
    .mode_i      (mode),
    .display_o   (dispA),
    .busy_o      (busyA),
    .done_o      (doneA),
    .step_o      (stepA)
  );

  display_scroller #(
    .N_DIGITS (4),
    .MSG_LEN  (6),
    .GAP      (0)
  ) dutB (
    .clk_10Mhz_i (clk),
    .rst_n_i     (rstN),
    .clk_en_i    (clkEn),
    .pause_i     (pause),
    .load_i      (load),
    .msg_i       (msgB),
    .dir_i       (dir),
    .mode_i      (mode),
    .display_o   (dispB),
    .busy_o      (busyB),
    .done_o      (doneB),
    .step_o      (stepB)
  );

  // 10 MHz system clock.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // The display is the tail of the inserted-character stream: the newest
  // character sits at the entry end, older ones further away.
  function automatic logic [31:0] modelDisplay(input int n, input int msgLen,
                                               input int gap, input logic [31:0] msg,
                                               input bit dirR, input int steps);
    logic [31:0] r;
    logic [31:0] tmp;
    logic [3:0]  ch;
    int          j;
    int          pos;
    r = '0;
    for (int d = 0; d < n; d++) begin
      j = steps - 1 - d;
      if (j >= 0) begin
        pos = j % (msgLen + gap);
        if (pos < msgLen) begin
          tmp = msg >> (4 * pos);
          ch  = tmp[3:0];
        end else begin
          ch = 4'h0;
        end
        if (dirR) r[4*(n-1-d) +: 4] = ch;
        else      r[4*d +: 4]       = ch;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of the default instance against the model.
  task automatic checkAll(input string tag);
    int expStep;
    bit expBusy;
    expStep = !mLoaded ? 0 : (mMode ? mSteps : mSteps % PASS_A);
    expBusy = mLoaded && (!mMode || mSteps < PASS_A);
    checkOutput({tag, ".disp"}, 64'(dispA), 64'(modelDisplay(8, 8, 8, mMsg, mDir, mSteps)));
    checkOutput({tag, ".busy"}, 64'(busyA), 64'(expBusy));
    checkOutput({tag, ".done"}, 64'(doneA), 64'(expDone));
    checkOutput({tag, ".step"}, 64'(stepA), 64'(expStep));
  endtask

  // One clock cycle: drive inputs at the falling edge, sample just after
  // the rising edge, and advance the model the same way.
  task automatic applyStimulus(input bit en, input bit pz, input bit ld);
    @(negedge clk);
    clkEn = en;
    pause = pz;
    load  = ld;
    @(posedge clk);
    #1;
    expDone = 0;
    if (ld) begin
      mLoaded = 1;
      mSteps  = 0;
      mMsg    = msgA;
      mDir    = dir;
      mMode   = mode;
    end else if (en && !pz && mLoaded && (!mMode || mSteps < PASS_A)) begin
      mSteps++;
      if (mMode && mSteps == PASS_A) expDone = 1;
    end
  endtask

  task automatic doSteps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0);
  endtask

  initial begin
    rstN  = 1'b0;
    clkEn = 1'b0;
    pause = 1'b0;
    load  = 1'b0;
    msgA  = 32'hEBEBE1AD;
    msgB  = 24'h654321;
    dir   = 1'b0;
    mode  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkAll("reset");
    rstN = 1'b1;
    applyStimulus(1, 0, 0);
    checkAll("idle_ignores_step");

    // Continuous scroll, left direction.
    $display("[TB] continuous left scroll");
    applyStimulus(0, 0, 1);
    checkAll("load");
    doSteps(1);
    checkOutput("cont.step1", 64'(dispA), 64'h0000000D);
    checkAll("cont1");
    doSteps(7);
    checkOutput("cont.step8", 64'(dispA), 64'hDA1EBEBE);
    checkAll("cont8");
    doSteps(8);
    checkOutput("cont.step16", 64'(dispA), 64'h00000000);
    checkAll("cont16");
    doSteps(1);
    checkOutput("cont.step17", 64'(dispA), 64'h0000000D);
    checkOutput("cont.step17.step", 64'(stepA), 64'd1);
    checkAll("cont17");

    // One-shot pass.
    $display("[TB] one-shot pass");
    mode = 1'b1;
    applyStimulus(0, 0, 1);
    doSteps(15);
    checkAll("oneshot15");
    doSteps(1);
    checkOutput("oneshot.done", 64'(doneA), 64'd1);
    checkOutput("oneshot.busy", 64'(busyA), 64'd0);
    checkAll("oneshot16");
    applyStimulus(0, 0, 0);
    checkOutput("oneshot.donePulse", 64'(doneA), 64'd0);
    doSteps(5);
    checkOutput("oneshot.hold", 64'(dispA), 64'h0);
    checkOutput("oneshot.stepHold", 64'(stepA), 64'd16);
    checkAll("oneshot_hold");

    // Right direction.
    $display("[TB] right direction");
    mode = 1'b0;
    dir  = 1'b1;
    applyStimulus(0, 0, 1);
    doSteps(1);
    checkOutput("right.step1", 64'(dispA), 64'hD0000000);
    doSteps(7);
    checkOutput("right.step8", 64'(dispA), 64'hEBEBE1AD);
    checkAll("right8");

    // Pause freezes everything; release resumes without losing a digit.
    $display("[TB] pause");
    dir = 1'b0;
    applyStimulus(0, 0, 1);
    doSteps(3);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0);
    checkOutput("pause.hold", 64'(dispA), 64'h00000DA1);
    checkOutput("pause.step", 64'(stepA), 64'd3);
    checkAll("pause");
    doSteps(1);
    checkOutput("pause.resume", 64'(dispA), 64'h0000DA1E);
    checkAll("resume");

    // Mid-pass input changes without load do nothing.
    msgA = 32'h12345678;
    dir  = 1'b1;
    doSteps(2);
    checkAll("noload_change");
    msgA = 32'hEBEBE1AD;
    dir  = 1'b0;

    // Load and clk_en together: the step is ignored.
    applyStimulus(1, 0, 1);
    checkOutput("loadstep.disp", 64'(dispA), 64'h0);
    checkOutput("loadstep.step", 64'(stepA), 64'd0);
    checkAll("loadstep");

    // Asynchronous reset between clock edges.
    $display("[TB] async reset");
    doSteps(5);
    applyStimulus(0, 0, 0);
    #20;
    rstN = 1'b0;
    #5;
    checkOutput("areset.disp", 64'(dispA), 64'h0);
    checkOutput("areset.busy", 64'(busyA), 64'd0);
    mLoaded = 0;
    mSteps  = 0;
    mMsg    = '0;
    expDone = 0;
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1, 0, 0);
    checkAll("after_reset");

    // Small instance: four digits, six characters, no gap.
    $display("[TB] corner instance");
    applyStimulus(0, 0, 1);
    doSteps(6);
    checkOutput("corner.step6", 64'(dispB), 64'h3456);
    checkOutput("corner.model6", 64'(dispB), 64'(modelDisplay(4, 6, 0, 32'(msgB), 0, mSteps)));
    doSteps(1);
    checkOutput("corner.step7", 64'(dispB), 64'h4561);
    checkOutput("corner.stepIdx", 64'(stepB), 64'd1);
    checkOutput("corner.busy", 64'(busyB), 64'd1);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int r = 0; r < 6; r++) begin
      msgA = $urandom;
      dir  = 1'($urandom % 2);
      mode = 1'($urandom % 2);
      applyStimulus(0, 0, 1);
      checkAll("rand_load");
      for (int c = 0; c < 60; c++) begin
        applyStimulus(1'($urandom % 2), ($urandom % 4) == 0, ($urandom % 40) == 0);
        checkAll("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
